// File: rtl/mac4_dot_accum.sv
// Sequential 4-bit dot-product engine around a combinational 4x4 tree multiplier.
// Define MAC4_DOT_SAT_EN to make the accumulator saturate instead of wrapping.

module mul4x4_tree (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] o
);
    logic [7:0] pp0, pp1, pp2, pp3;
    logic [7:0] s01, s23;

    // Shifted partial products reduced as a two-level adder tree.
    assign pp0 = {4'b0000, x & {4{y[0]}}};
    assign pp1 = {3'b000, x & {4{y[1]}}, 1'b0};
    assign pp2 = {2'b00, x & {4{y[2]}}, 2'b00};
    assign pp3 = {1'b0, x & {4{y[3]}}, 3'b000};
    assign s01 = pp0 + pp1;
    assign s23 = pp2 + pp3;
    assign o   = s01 + s23;
endmodule

module mac4_dot_accum #(
    parameter int ACC_W = 16,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_x,
    input  logic [3:0]       in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             va_q, vb_q;
    logic [3:0]       xa_q, ya_q;
    logic [7:0]       prod_q;
    logic [7:0]       mult_o;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum_w;
    logic             hs;

    mul4x4_tree u_mul (
        .x (xa_q),
        .y (ya_q),
        .o (mult_o)
    );

    assign in_ready  = (state_q == S_RUN);
    assign hs        = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign sum_w     = {1'b0, acc_q} + (ACC_W+1)'(prod_q);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;

        if (vb_q) begin
`ifdef MAC4_DOT_SAT_EN
            acc_d = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
            acc_d = sum_w[ACC_W-1:0];
`endif
            ovf_d = ovf_q | sum_w[ACC_W];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    remaining_d = len;
                    state_d     = (len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (hs) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Both pipeline stages must be empty so the last product is already in acc.
                if (!va_q && !vb_q) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            va_q        <= 1'b0;
            vb_q        <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            va_q        <= hs;
            vb_q        <= va_q;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: operand and product registers carry no reset; their valid bits guard every use.
    always_ff @(posedge clk) begin
        if (hs) begin
            xa_q <= in_x;
            ya_q <= in_y;
        end
        if (va_q) prod_q <= mult_o;
    end
endmodule

// File: tb/tb_mac4_dot_accum.sv
// Directed bench for mac4_dot_accum: a 16-bit and a 10-bit instance share all inputs.
// Overflow expectations follow MAC4_DOT_SAT_EN when it is defined for the build.

module tb_mac4_dot_accum;
`ifdef MAC4_DOT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [3:0]      len;
        logic [2:0][3:0] xs;
        logic [2:0][3:0] ys;
        logic [3:0]      fx;
        logic [3:0]      fy;
        int              e16;
        int              o16;
        int              e10;
        int              o10;
    } job_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_x = '0;
    logic [3:0]  in_y = '0;
    logic        out_ready = 1'b0;

    logic        in_ready16, out_valid16, out_ovf16, busy16;
    logic [15:0] out_sum16;
    logic        in_ready10, out_valid10, out_ovf10, busy10;
    logic [9:0]  out_sum10;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    job_t jobs[5];

    mac4_dot_accum #(.ACC_W(16), .LEN_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready16), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid16), .out_ready(out_ready), .out_sum(out_sum16),
        .out_ovf(out_ovf16), .busy(busy16)
    );

    mac4_dot_accum #(.ACC_W(10), .LEN_W(4)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready10), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid10), .out_ready(out_ready), .out_sum(out_sum10),
        .out_ovf(out_ovf10), .busy(busy10)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (in_valid && in_ready16) hs_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, inout bit busy_ok);
        n = 0;
        while (!out_valid16 && n < 20) begin
            tick();
            n++;
            if (!busy16) busy_ok = 1'b0;
        end
    endtask

    task automatic accept(input string tag, input int e16);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " idle busy"}, 32'(busy16), 0);
        check({tag, " idle out_valid"}, 32'(out_valid16), 0);
        check({tag, " idle sum held"}, 32'(out_sum16), e16);
    endtask

    task automatic run_job(input job_t j, input string tag);
        int n;
        int h0;
        bit busy_ok;
        busy_ok = 1'b1;
        h0 = hs_cnt;
        start_job(j.len);
        if (!busy16 && j.len != 0) busy_ok = 1'b0;
        for (int i = 0; i < int'(j.len); i++) begin
            in_valid = 1'b1;
            if (i < 3) begin
                in_x = j.xs[i];
                in_y = j.ys[i];
            end else begin
                in_x = j.fx;
                in_y = j.fy;
            end
            tick();
            if (!busy16) busy_ok = 1'b0;
        end
        in_valid = 1'b0;
        wait_done(n, busy_ok);
        check({tag, " latency"}, n, (j.len != 0) ? 3 : 0);
        check({tag, " handshakes"}, hs_cnt - h0, 32'(j.len));
        check({tag, " busy"}, 32'(busy_ok), 1);
        check({tag, " sum16"}, 32'(out_sum16), j.e16);
        check({tag, " ovf16"}, 32'(out_ovf16), j.o16);
        check({tag, " sum10"}, 32'(out_sum10), j.e10);
        check({tag, " ovf10"}, 32'(out_ovf10), j.o10);
        accept(tag, j.e16);
    endtask

    initial begin
        int n;
        int h0;
        bit busy_ok;
        job_t j;

        jobs[0] = '{4'd3, {4'd7, 4'd15, 4'd3}, {4'd2, 4'd15, 4'd5}, 4'd0, 4'd0, 254, 0, 254, 0};
        jobs[1] = '{4'd2, {4'd0, 4'd8, 4'd0}, {4'd0, 4'd8, 4'd9}, 4'd0, 4'd0, 64, 0, 64, 0};
        jobs[2] = '{4'd5, {4'd15, 4'd15, 4'd15}, {4'd15, 4'd15, 4'd15}, 4'd15, 4'd15,
                    1125, 0, SAT ? 1023 : 101, 1};
        jobs[3] = '{4'd15, {4'd15, 4'd15, 4'd15}, {4'd15, 4'd15, 4'd15}, 4'd15, 4'd15,
                    3375, 0, SAT ? 1023 : 303, 1};
        jobs[4] = '{4'd1, {4'd0, 4'd0, 4'd15}, {4'd0, 4'd0, 4'd0}, 4'd0, 4'd0, 0, 0, 0, 0};

        // Reset state
        tick();
        tick();
        check("reset in_ready", 32'(in_ready16), 0);
        check("reset out_valid", 32'(out_valid16), 0);
        check("reset out_sum", 32'(out_sum16), 0);
        check("reset out_ovf", 32'(out_ovf16), 0);
        check("reset busy", 32'(busy16), 0);
        check("reset out_sum10", 32'(out_sum10), 0);
        rst_n = 1'b1;
        tick();

        // Table jobs: basic, mixed, overflow at ACC_W=10, longest job, zero product
        for (int k = 0; k < 5; k++) run_job(jobs[k], $sformatf("job%0d", k));

        // Throttled input with operands offered during DRAIN
        h0 = hs_cnt;
        busy_ok = 1'b1;
        start_job(4'd4);
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_x = 4'(i);
            in_y = 4'(i);
            tick();
            in_valid = 1'b0;
            if (i == 4) begin
                check("throttle in_ready after last", 32'(in_ready16), 0);
                in_valid = 1'b1;
                in_x = 4'd15;
                in_y = 4'd15;
            end
            tick();
        end
        wait_done(n, busy_ok);
        in_valid = 1'b0;
        check("throttle handshakes", hs_cnt - h0, 4);
        check("throttle done", 32'(out_valid16), 1);
        check("throttle sum", 32'(out_sum16), 30);
        check("throttle ovf", 32'(out_ovf16), 0);
        accept("throttle", 30);

        // Zero length, backpressure, start ignored in DONE
        start_job(4'd0);
        check("len0 out_valid", 32'(out_valid16), 1);
        check("len0 sum", 32'(out_sum16), 0);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            len = 4'd3;
            tick();
            check($sformatf("bp%0d out_valid", i), 32'(out_valid16), 1);
            check($sformatf("bp%0d sum", i), 32'(out_sum16), 0);
        end
        start = 1'b0;
        accept("len0", 0);
        tick();
        check("len0 stays idle", 32'(busy16), 0);

        // Reset mid-job after 3 handshakes
        start_job(4'd6);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_x = 4'd13;
            in_y = 4'd11;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst in_ready", 32'(in_ready16), 0);
        check("midrst out_valid", 32'(out_valid16), 0);
        check("midrst out_sum", 32'(out_sum16), 0);
        check("midrst out_ovf", 32'(out_ovf16), 0);
        check("midrst busy", 32'(busy16), 0);
        tick();
        tick();
        tick();
        check("midrst no result", 32'(out_valid16 | busy16), 0);
        j = jobs[4];
        j.xs = '0;
        j.ys = '0;
        j.xs[0] = 4'd9;
        j.ys[0] = 4'd9;
        j.e16 = 81;
        j.e10 = 81;
        run_job(j, "after_rst");

        // Every operand pair as a single-term job
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                j = jobs[4];
                j.xs = '0;
                j.ys = '0;
                j.xs[0] = 4'(x);
                j.ys[0] = 4'(y);
                j.e16 = x * y;
                j.e10 = x * y;
                run_job(j, $sformatf("mul%0dx%0d", x, y));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
